imem_fetch: RTL and testbench



---
 rtl/imem_pkg.sv | 25 ++
 rtl/imem_fetch_if.sv | 37 +++
 rtl/imem_byte_array.sv | 43 ++++
 rtl/imem_fetch.sv | 117 +++++++++++
 tb/tb_imem_fetch.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_pkg.sv
// Shared types and parameter checks for the instruction memory.
// Fault codes are the rsp_fault encoding seen by the fetch stage.
package imem_pkg;

  typedef enum logic [1:0] {
    FAULT_NONE     = 2'b00,
    FAULT_MISALIGN = 2'b01,
    FAULT_RANGE    = 2'b10
  } fault_e;

  // FETCH_BYTES must be a power of two >= 2.
  // DEPTH must be non-zero and fit the address space.
  function automatic bit params_ok(
    input int aw,
    input int depth,
    input int fb
  );
    return (fb >= 2)
      && ((fb & (fb - 1)) == 0)
      && (depth >= 1)
      && (aw >= 1)
      && (longint'(depth) <= (longint'(1) << aw));
  endfunction

endpackage

// File: rtl/imem_fetch_if.sv
// Fetch request/response, flush and loader signals of imem_fetch.
// master: PC/fetch stage or bench; slave: the memory.
interface imem_fetch_if #(
  parameter int ADDR_WIDTH  = 10,
  parameter int FETCH_BYTES = 4
);
  logic                     req_valid;
  logic                     req_ready;
  logic [ADDR_WIDTH-1:0]    req_addr;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [8*FETCH_BYTES-1:0] rsp_data;
  logic [ADDR_WIDTH-1:0]    rsp_addr;
  logic [1:0]               rsp_fault;
  logic                     flush;
  logic                     ld_en;
  logic [ADDR_WIDTH-1:0]    ld_addr;
  logic [7:0]               ld_data;

  modport master (
    output req_valid, req_addr,
    input  req_ready,
    input  rsp_valid, rsp_data,
    input  rsp_addr, rsp_fault,
    output rsp_ready, flush,
    output ld_en, ld_addr, ld_data
  );

  modport slave (
    input  req_valid, req_addr,
    output req_ready,
    output rsp_valid, rsp_data,
    output rsp_addr, rsp_fault,
    input  rsp_ready, flush,
    input  ld_en, ld_addr, ld_data
  );
endinterface

// File: rtl/imem_byte_array.sv
// DEPTH x 8 byte store: one byte write port, FETCH_BYTES-wide async read.
// Ports: clk_i, we_i/waddr_i/wdata_i (write), raddr_i/rdata_o (read).
module imem_byte_array #(
  parameter int ADDR_WIDTH  = 10,
  parameter int DEPTH       = 1024,
  parameter int FETCH_BYTES = 4
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [ADDR_WIDTH-1:0]    waddr_i,
  input  logic [7:0]               wdata_i,
  input  logic [ADDR_WIDTH-1:0]    raddr_i,
  output logic [8*FETCH_BYTES-1:0] rdata_o
);
  localparam int IW =
    (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_W =
    (ADDR_WIDTH+1)'(DEPTH);

  logic [7:0] mem_q [DEPTH];
  logic [ADDR_WIDTH:0] widx;

  assign widx = {1'b0, waddr_i};

  // Contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (we_i && (widx < DEPTH_W)) begin
      mem_q[widx[IW-1:0]] <= wdata_i;
    end
  end

  // Bytes past the end read as zero; the
  // range fault masks them anyway.
  for (genvar g = 0; g < FETCH_BYTES; g++) begin : g_rd
    logic [ADDR_WIDTH:0] ridx;
    assign ridx = {1'b0, raddr_i}
      + (ADDR_WIDTH+1)'(g);
    assign rdata_o[8*g +: 8] =
      (ridx < DEPTH_W) ? mem_q[ridx[IW-1:0]]
                       : 8'h00;
  end

endmodule

// File: rtl/imem_fetch.sv
// Instruction memory with registered valid/ready fetch port and loader.
// Ports: clk, rst (async, active-high), fetch_if (slave modport).
module imem_fetch
  import imem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int DEPTH       = 1024,
  parameter int FETCH_BYTES = 4,
  parameter int HALF_ALIGN  = 0
) (
  input logic        clk,
  input logic        rst,
  imem_fetch_if.slave fetch_if
);
  localparam int AW = ADDR_WIDTH;
  localparam int FW = 8 * FETCH_BYTES;
  localparam int ALIGN =
    (HALF_ALIGN != 0) ? 2 : FETCH_BYTES;
  localparam logic [AW-1:0] AMASK =
    AW'(ALIGN - 1);
  localparam logic [AW:0] DEPTH_W =
    (AW+1)'(DEPTH);
  localparam logic [AW:0] LAST_OFS =
    (AW+1)'(FETCH_BYTES - 1);

  if (!params_ok(AW, DEPTH, FETCH_BYTES))
  begin : g_bad_params
    $error("imem_fetch: bad parameters");
  end

  logic [FW-1:0] rd_data;
  logic [AW:0]   last_addr;
  logic          misalign;
  logic          out_range;
  logic          accept;
  fault_e        fault;

  logic          valid_q, valid_d;
  logic [FW-1:0] data_q, data_d;
  logic [AW-1:0] addr_q, addr_d;
  fault_e        fault_q, fault_d;

  imem_byte_array #(
    .ADDR_WIDTH (AW),
    .DEPTH      (DEPTH),
    .FETCH_BYTES(FETCH_BYTES)
  ) u_mem (
    .clk_i  (clk),
    .we_i   (fetch_if.ld_en),
    .waddr_i(fetch_if.ld_addr),
    .wdata_i(fetch_if.ld_data),
    .raddr_i(fetch_if.req_addr),
    .rdata_o(rd_data)
  );

  // One extra bit so the end address cannot wrap.
  assign last_addr =
    {1'b0, fetch_if.req_addr} + LAST_OFS;
  assign misalign =
    |(fetch_if.req_addr & AMASK);
  assign out_range = last_addr >= DEPTH_W;

  always_comb begin
    fault = FAULT_NONE;
    if (misalign) begin
      fault = FAULT_MISALIGN;
    end else if (out_range) begin
      fault = FAULT_RANGE;
    end
  end

  assign fetch_if.req_ready = !rst
    && !fetch_if.ld_en
    && !fetch_if.flush
    && (!valid_q || fetch_if.rsp_ready);

  assign accept =
    fetch_if.req_valid && fetch_if.req_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    addr_d  = addr_q;
    fault_d = fault_q;
    if (fetch_if.flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      addr_d  = fetch_if.req_addr;
      fault_d = fault;
      data_d  = (fault == FAULT_NONE)
        ? rd_data : '0;
    end else if (fetch_if.rsp_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      addr_q  <= '0;
      fault_q <= FAULT_NONE;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      fault_q <= fault_d;
    end
  end

  assign fetch_if.rsp_valid = valid_q;
  assign fetch_if.rsp_data  = data_q;
  assign fetch_if.rsp_addr  = addr_q;
  assign fetch_if.rsp_fault = fault_q;

endmodule

// File: tb/tb_imem_fetch.sv
// Directed bench for imem_fetch: word-aligned and half-aligned instances.
// Expected values are hand-computed from the loaded byte images.
module tb_imem_fetch;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  imem_fetch_if #(.ADDR_WIDTH(10), .FETCH_BYTES(4)) a_if ();
  imem_fetch_if #(.ADDR_WIDTH(10), .FETCH_BYTES(4)) b_if ();

  imem_fetch #(
    .ADDR_WIDTH(10), .DEPTH(1024),
    .FETCH_BYTES(4), .HALF_ALIGN(0)
  ) u_a (
    .clk     (clk),
    .rst     (rst),
    .fetch_if(a_if.slave)
  );

  imem_fetch #(
    .ADDR_WIDTH(10), .DEPTH(512),
    .FETCH_BYTES(4), .HALF_ALIGN(1)
  ) u_b (
    .clk     (clk),
    .rst     (rst),
    .fetch_if(b_if.slave)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %h want %h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_ld(
    input logic [9:0] ad, input logic [7:0] d
  );
    a_if.ld_en = 1'b1;
    a_if.ld_addr = ad;
    a_if.ld_data = d;
    tick();
    a_if.ld_en = 1'b0;
  endtask

  task automatic b_ld(
    input logic [9:0] ad, input logic [7:0] d
  );
    b_if.ld_en = 1'b1;
    b_if.ld_addr = ad;
    b_if.ld_data = d;
    tick();
    b_if.ld_en = 1'b0;
  endtask

  // Issue one request and return after its accept edge.
  task automatic a_fetch(input logic [9:0] ad);
    a_if.req_valid = 1'b1;
    a_if.req_addr = ad;
    tick();
    a_if.req_valid = 1'b0;
  endtask

  task automatic b_fetch(input logic [9:0] ad);
    b_if.req_valid = 1'b1;
    b_if.req_addr = ad;
    tick();
    b_if.req_valid = 1'b0;
  endtask

  logic [31:0] exp_w [4];

  initial begin
    a_if.req_valid = 0; a_if.req_addr = '0;
    a_if.rsp_ready = 1; a_if.flush = 0;
    a_if.ld_en = 0; a_if.ld_addr = '0;
    a_if.ld_data = '0;
    b_if.req_valid = 0; b_if.req_addr = '0;
    b_if.rsp_ready = 1; b_if.flush = 0;
    b_if.ld_en = 0; b_if.ld_addr = '0;
    b_if.ld_data = '0;

    #2;
    chk("rst_valid", 32'(a_if.rsp_valid), 0);
    chk("rst_ready", 32'(a_if.req_ready), 0);
    chk("rst_data", a_if.rsp_data, 0);
    tick();
    rst = 1'b0;

    // Image: 13 05 10 00, then byte k = k for 4..15.
    a_ld(10'd0, 8'h13);
    a_ld(10'd1, 8'h05);
    a_ld(10'd2, 8'h10);
    a_ld(10'd3, 8'h00);
    for (int k = 4; k < 16; k++) a_ld(10'(k), 8'(k));
    for (int k = 0; k < 8; k++)
      b_ld(10'(k), 8'(8'h10 + k));

    // Single fetch.
    a_if.req_valid = 1; a_if.req_addr = 0;
    #1;
    chk("first_ready", 32'(a_if.req_ready), 1);
    tick();
    a_if.req_valid = 0;
    chk("first_valid", 32'(a_if.rsp_valid), 1);
    chk("first_data", a_if.rsp_data, 32'h00100513);
    chk("first_fault", 32'(a_if.rsp_fault), 0);
    tick();
    chk("drain_valid", 32'(a_if.rsp_valid), 0);

    // Back-to-back stream.
    exp_w[0] = 32'h00100513;
    exp_w[1] = 32'h07060504;
    exp_w[2] = 32'h0B0A0908;
    exp_w[3] = 32'h0F0E0D0C;
    for (int k = 0; k < 4; k++) begin
      a_if.req_valid = 1;
      a_if.req_addr = 10'(4 * k);
      #1;
      chk("strm_ready", 32'(a_if.req_ready), 1);
      tick();
      chk("strm_valid", 32'(a_if.rsp_valid), 1);
      chk("strm_data", a_if.rsp_data, exp_w[k]);
      chk("strm_addr", 32'(a_if.rsp_addr), 4 * k);
    end
    a_if.req_valid = 0;
    tick();
    chk("strm_end", 32'(a_if.rsp_valid), 0);

    // Back-pressure with a loader write behind it.
    a_if.rsp_ready = 0;
    a_fetch(10'd0);
    a_if.req_valid = 1; a_if.req_addr = 10'd4;
    for (int k = 0; k < 3; k++) begin
      a_if.ld_en = (k == 0);
      a_if.ld_addr = 10'd0;
      a_if.ld_data = 8'hFF;
      #1;
      chk("bp_ready", 32'(a_if.req_ready), 0);
      tick();
      chk("bp_valid", 32'(a_if.rsp_valid), 1);
      chk("bp_data", a_if.rsp_data, 32'h00100513);
      chk("bp_addr", 32'(a_if.rsp_addr), 0);
    end
    a_if.ld_en = 0;
    a_if.rsp_ready = 1;
    a_if.req_addr = 10'd0;
    #1;
    chk("rel_ready", 32'(a_if.req_ready), 1);
    tick();
    a_if.req_valid = 0;
    chk("refetch", a_if.rsp_data, 32'h001005FF);
    tick();

    // Alignment and range, word-aligned instance.
    a_fetch(10'd2);
    chk("a2_fault", 32'(a_if.rsp_fault), 1);
    chk("a2_data", a_if.rsp_data, 0);
    a_fetch(10'd1022);
    chk("a1022_fault", 32'(a_if.rsp_fault), 1);
    a_fetch(10'd1020);
    chk("a1020_fault", 32'(a_if.rsp_fault), 0);
    tick();

    // Half-aligned instance, DEPTH 512.
    b_fetch(10'd2);
    chk("b2_fault", 32'(b_if.rsp_fault), 0);
    chk("b2_data", b_if.rsp_data, 32'h15141312);
    b_fetch(10'd3);
    chk("b3_fault", 32'(b_if.rsp_fault), 1);
    chk("b3_data", b_if.rsp_data, 0);
    b_fetch(10'd510);
    chk("b510_fault", 32'(b_if.rsp_fault), 2);
    chk("b510_data", b_if.rsp_data, 0);
    b_fetch(10'd508);
    chk("b508_fault", 32'(b_if.rsp_fault), 0);
    b_ld(10'd512, 8'hAA);
    b_fetch(10'd0);
    chk("b_oob_ld", b_if.rsp_data, 32'h13121110);
    tick();

    // Flush over a held response with a pending request.
    a_if.rsp_ready = 0;
    a_fetch(10'd0);
    a_if.flush = 1;
    a_if.req_valid = 1; a_if.req_addr = 10'd4;
    #1;
    chk("fl_ready", 32'(a_if.req_ready), 0);
    tick();
    a_if.flush = 0;
    chk("fl_valid", 32'(a_if.rsp_valid), 0);
    #1;
    chk("fl_ready2", 32'(a_if.req_ready), 1);
    tick();
    a_if.req_valid = 0;
    chk("fl_acc", 32'(a_if.rsp_valid), 1);
    chk("fl_addr", 32'(a_if.rsp_addr), 4);
    chk("fl_data", a_if.rsp_data, 32'h07060504);
    a_if.rsp_ready = 1;
    tick();

    // Asynchronous reset mid-stream.
    a_fetch(10'd8);
    chk("pre_rst", a_if.rsp_data, 32'h0B0A0908);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_valid", 32'(a_if.rsp_valid), 0);
    chk("ar_data", a_if.rsp_data, 0);
    chk("ar_addr", 32'(a_if.rsp_addr), 0);
    chk("ar_fault", 32'(a_if.rsp_fault), 0);
    chk("ar_ready", 32'(a_if.req_ready), 0);
    tick();
    rst = 1'b0;
    a_if.req_valid = 1; a_if.req_addr = 10'd0;
    #1;
    chk("post_ready", 32'(a_if.req_ready), 1);
    tick();
    a_if.req_valid = 0;
    chk("post_valid", 32'(a_if.rsp_valid), 1);
    chk("post_data", a_if.rsp_data, 32'h001005FF);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
